// File: rtl/piso_serializer_8bit_if.sv
// Load handshake and serial-line bundle for the PISO serializer.
// The slave modport is the serializer; the master modport is the producer/observer.
interface piso_serializer_8bit_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] D;
    logic             sOut;
    logic             sValid;
    logic             busy;
    logic             done;

    modport master (
        output load_valid, D,
        input  load_ready, sOut, sValid, busy, done
    );

    modport slave (
        input  load_valid, D,
        output load_ready, sOut, sValid, busy, done
    );
endinterface

// File: rtl/piso_serializer_8bit.sv
// LSB-first parallel-to-serial transmitter with valid/ready load and done strobe.
// Define PARITY_EN to append an even-parity bit after the MSB of every frame.
module piso_serializer_8bit #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    piso_serializer_8bit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             done_q, done_n;
    logic             last_bit;
    logic             load_ready;
    logic             accept;
`ifdef PARITY_EN
    logic             par_q, par_n;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            shreg  <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
`ifdef PARITY_EN
            par_q  <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            shreg  <= shreg_n;
            cnt    <= cnt_n;
            done_q <= done_n;
`ifdef PARITY_EN
            par_q  <= par_n;
`endif
        end
    end

    // The final frame bit opens the load window so frames can abut.
`ifdef PARITY_EN
    assign last_bit = (state == PARITY);
`else
    assign last_bit = (state == SHIFT) && (cnt == LAST);
`endif
    assign load_ready = (state == IDLE) | last_bit;
    assign accept     = bus.load_valid & load_ready;

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        cnt_n   = cnt;
        done_n  = 1'b0;
`ifdef PARITY_EN
        par_n   = par_q;
`endif
        if (accept) begin
            state_n = SHIFT;
            shreg_n = bus.D;
            cnt_n   = '0;
            done_n  = (state != IDLE);
`ifdef PARITY_EN
            par_n   = ^bus.D;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                end
                SHIFT: begin
                    if (cnt == LAST) begin
`ifdef PARITY_EN
                        state_n = PARITY;
                        shreg_n = WIDTH'(par_q);
`else
                        state_n = IDLE;
                        shreg_n = '0;
                        cnt_n   = '0;
                        done_n  = 1'b1;
`endif
                    end else begin
                        shreg_n = shreg >> 1;
                        cnt_n   = cnt + CW'(1);
                    end
                end
`ifdef PARITY_EN
                PARITY: begin
                    state_n = IDLE;
                    shreg_n = '0;
                    cnt_n   = '0;
                    done_n  = 1'b1;
                end
`endif
                default: begin
                end
            endcase
        end
    end

    // Bit 0 of the shift register is the line; it is zero whenever idle.
    assign bus.sOut       = shreg[0];
    assign bus.sValid     = (state != IDLE);
    assign bus.busy       = (state != IDLE);
    assign bus.done       = done_q;
    assign bus.load_ready = load_ready;
endmodule

// File: tb/tb_piso_serializer_8bit.sv
// Self-checking bench for piso_serializer_8bit: random words against a bit-queue model
// plus an 8-bit SIPO receiver model on the serial line.
module tb_piso_serializer_8bit;
    localparam int W = 8;
`ifdef PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    piso_serializer_8bit_if #(.WIDTH(W)) bus ();

    piso_serializer_8bit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b0;
        bus.load_valid = 1'b1;
        bus.D = 8'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if (bus.sOut !== 1'b0) $display("FAIL rst_sOut: got %b want 0", bus.sOut);
        else n_pass++;
        n_chk++;
        if (bus.sValid !== 1'b0) $display("FAIL rst_sValid: got %b want 0", bus.sValid);
        else n_pass++;
        n_chk++;
        if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy);
        else n_pass++;
        n_chk++;
        if (bus.done !== 1'b0) $display("FAIL rst_done: got %b want 0", bus.done);
        else n_pass++;
        n_chk++;
        if (bus.load_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", bus.load_ready);
        else n_pass++;
        bus.load_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [W-1:0] w = 8'hA5;
        bit exp_q[$];
        for (int i = 0; i < W; i++) exp_q.push_back(w[i]);
`ifdef PARITY_EN
        exp_q.push_back(^w);
`endif
        n_chk++;
        if (bus.load_ready !== 1'b1) $display("FAIL a5_ready: got %b want 1", bus.load_ready);
        else n_pass++;
        bus.load_valid = 1'b1;
        bus.D = w;
        @(negedge clk);
        bus.load_valid = 1'b0;
        bus.D = 8'($urandom);
        for (int k = 0; k < FRAME; k++) begin
            n_chk++;
            if (bus.sValid !== 1'b1 || bus.sOut !== exp_q[k] || bus.done !== 1'b0)
                $display("FAIL a5_bit%0d: got v=%b d=%b done=%b want v=1 d=%b done=0",
                         k, bus.sValid, bus.sOut, bus.done, exp_q[k]);
            else n_pass++;
            @(negedge clk);
        end
        n_chk++;
        if (bus.done !== 1'b1 || bus.sValid !== 1'b0 || bus.busy !== 1'b0 || bus.sOut !== 1'b0)
            $display("FAIL a5_end: got done=%b v=%b busy=%b d=%b want 1 0 0 0",
                     bus.done, bus.sValid, bus.busy, bus.sOut);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (bus.done !== 1'b0) $display("FAIL a5_done_width: got %b want 0", bus.done);
        else n_pass++;
    endtask

    task automatic test_loopback();
        logic [W-1:0] sent[$];
        logic [W-1:0] words[$];
        logic [W-1:0] q = '0;
        bit exp_q[$];
        int bitpos = 0;
        int idx = 0;
        int got = 0;
        int cyc = 0;
        for (int i = 0; i < 50; i++) words.push_back(W'($urandom));
        while (got < 50 && cyc < 3000) begin
            if (bus.done) begin
                n_chk++;
                if (sent.size() == 0) $display("FAIL lb_spurious_done: got done=1 want 0");
                else begin
                    logic [W-1:0] e = sent.pop_front();
                    if (q !== e) $display("FAIL lb_word%0d: got %h want %h", got, q, e);
                    else n_pass++;
                end
                got++;
            end
            if (bus.sValid) begin
                n_chk++;
                if (exp_q.size() == 0) $display("FAIL lb_extra_bit: got v=1 want v=0");
                else begin
                    bit e = exp_q.pop_front();
                    if (bus.sOut !== e) $display("FAIL lb_bit: got %b want %b", bus.sOut, e);
                    else n_pass++;
                end
                if (bitpos < W) q = {bus.sOut, q[W-1:1]};
                bitpos = (bitpos + 1) % FRAME;
            end
            if (idx < 50 && ($urandom % 4) != 0) begin
                bus.load_valid = 1'b1;
                bus.D = words[idx];
                if (bus.load_ready) begin
                    sent.push_back(words[idx]);
                    for (int i = 0; i < W; i++) exp_q.push_back(words[idx][i]);
`ifdef PARITY_EN
                    exp_q.push_back(^words[idx]);
`endif
                    idx++;
                end
            end else begin
                bus.load_valid = 1'b0;
                bus.D = W'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        bus.load_valid = 1'b0;
        n_chk++;
        if (got != 50) $display("FAIL lb_timeout: got %0d frames want 50", got);
        else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words[2] = '{8'h3C, 8'hC3};
        bit exp_q[$];
        int idx = 0, ndone = 0, nvalid = 0, first = -1, last = -1;
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < W; i++) exp_q.push_back(words[j][i]);
`ifdef PARITY_EN
            exp_q.push_back(^words[j]);
`endif
        end
        for (int cyc = 0; cyc < 2 * FRAME + 4; cyc++) begin
            if (bus.done) ndone++;
            if (bus.sValid) begin
                if (first < 0) first = cyc;
                last = cyc;
                nvalid++;
                n_chk++;
                if (exp_q.size() == 0) $display("FAIL b2b_extra_bit: got v=1 want v=0");
                else begin
                    bit e = exp_q.pop_front();
                    if (bus.sOut !== e) $display("FAIL b2b_bit%0d: got %b want %b", nvalid - 1, bus.sOut, e);
                    else n_pass++;
                end
            end
            if (idx < 2) begin
                bus.load_valid = 1'b1;
                bus.D = words[idx];
                if (bus.load_ready) idx++;
            end else bus.load_valid = 1'b0;
            @(negedge clk);
        end
        n_chk++;
        if (nvalid != 2 * FRAME || last - first + 1 != 2 * FRAME)
            $display("FAIL b2b_contig: got %0d valid over %0d cycles want %0d", nvalid, last - first + 1, 2 * FRAME);
        else n_pass++;
        n_chk++;
        if (ndone != 2) $display("FAIL b2b_done: got %0d pulses want 2", ndone);
        else n_pass++;
    endtask

    task automatic test_ignore_midframe();
        logic [W-1:0] w = W'($urandom);
        bit exp_q[$];
        int extra = 0;
        for (int i = 0; i < W; i++) exp_q.push_back(w[i]);
`ifdef PARITY_EN
        exp_q.push_back(^w);
`endif
        bus.load_valid = 1'b1;
        bus.D = w;
        @(negedge clk);
        for (int k = 0; k < FRAME; k++) begin
            n_chk++;
            if (bus.sValid !== 1'b1 || bus.sOut !== exp_q[k])
                $display("FAIL ign_bit%0d: got v=%b d=%b want v=1 d=%b", k, bus.sValid, bus.sOut, exp_q[k]);
            else n_pass++;
            if (k >= 1 && k <= 4) begin
                n_chk++;
                if (bus.load_ready !== 1'b0) $display("FAIL ign_ready%0d: got %b want 0", k, bus.load_ready);
                else n_pass++;
                bus.load_valid = 1'b1;
                bus.D = 8'hFF;
            end else bus.load_valid = 1'b0;
            @(negedge clk);
        end
        n_chk++;
        if (bus.done !== 1'b1) $display("FAIL ign_done: got %b want 1", bus.done);
        else n_pass++;
        for (int k = 0; k < FRAME + 2; k++) begin
            if (bus.sValid !== 1'b0) extra++;
            @(negedge clk);
        end
        n_chk++;
        if (extra != 0) $display("FAIL ign_extra_frame: got %0d valid cycles want 0", extra);
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        logic [W-1:0] w = 8'hF0;
        logic [W-1:0] w2 = W'($urandom);
        bit exp_q[$];
        bus.load_valid = 1'b1;
        bus.D = w;
        @(negedge clk);
        bus.load_valid = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            n_chk++;
            if (bus.sOut !== w[k]) $display("FAIL mrst_bit%0d: got %b want %b", k, bus.sOut, w[k]);
            else n_pass++;
            if (k < 4) @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (bus.sOut !== 1'b0 || bus.sValid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0)
            $display("FAIL mrst_abort: got d=%b v=%b busy=%b done=%b want 0 0 0 0",
                     bus.sOut, bus.sValid, bus.busy, bus.done);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_chk++;
        if (bus.done !== 1'b0 || bus.load_ready !== 1'b1)
            $display("FAIL mrst_after: got done=%b ready=%b want 0 1", bus.done, bus.load_ready);
        else n_pass++;
        for (int i = 0; i < W; i++) exp_q.push_back(w2[i]);
`ifdef PARITY_EN
        exp_q.push_back(^w2);
`endif
        bus.load_valid = 1'b1;
        bus.D = w2;
        @(negedge clk);
        bus.load_valid = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
            n_chk++;
            if (bus.sValid !== 1'b1 || bus.sOut !== exp_q[k])
                $display("FAIL mrst_fresh%0d: got v=%b d=%b want v=1 d=%b", k, bus.sValid, bus.sOut, exp_q[k]);
            else n_pass++;
            @(negedge clk);
        end
        n_chk++;
        if (bus.done !== 1'b1) $display("FAIL mrst_fresh_done: got %b want 1", bus.done);
        else n_pass++;
        @(negedge clk);
    endtask

`ifdef PARITY_EN
    task automatic test_parity();
        logic [W-1:0] words[2] = '{8'h07, 8'h03};
        logic         pars[2] = '{1'b1, 1'b0};
        for (int j = 0; j < 2; j++) begin
            bus.load_valid = 1'b1;
            bus.D = words[j];
            @(negedge clk);
            bus.load_valid = 1'b0;
            repeat (W) @(negedge clk);
            n_chk++;
            if (bus.sValid !== 1'b1 || bus.sOut !== pars[j])
                $display("FAIL par_%h: got v=%b d=%b want v=1 d=%b", words[j], bus.sValid, bus.sOut, pars[j]);
            else n_pass++;
            repeat (2) @(negedge clk);
        end
    endtask
`endif

    initial begin
        bus.load_valid = 1'b0;
        bus.D = '0;
        test_reset();
        test_single();
        test_loopback();
        test_back_to_back();
        test_ignore_midframe();
        test_reset_midframe();
`ifdef PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
